// File: rtl/if_fetch_queue.sv
// if_fetch_queue: prefetching fetch stage, one outstanding imem request, DEPTH-entry {pc+step, instr} queue.
// Define IF_FETCH_QUEUE_BYPASS_EN to forward an ack straight to the output when the queue is empty.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_addr,
    input  logic            freeze,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc4,
    output logic [XLEN-1:0] out_instr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} mem_state_t;

    mem_state_t      mem_state, mem_state_nx;
    logic [XLEN-1:0] fetch_pc, req_pc, req_pc4;
    logic [XLEN-1:0] pc4_q   [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count, count_nx;
    logic            ack_ok, byp, push, pop_q, slot_free, issue;

    assign req_pc4 = req_pc + PC_STEP;
    assign ack_ok  = mem_state == WAIT && imem_ack && !br_taken;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    assign byp = ack_ok && count == '0;
`else
    assign byp = 1'b0;
`endif
    // A bypassed response that is consumed right away never enters the queue.
    assign pop_q     = count != '0 && !freeze && !br_taken;
    assign push      = ack_ok && !(byp && !freeze);
    assign count_nx  = count + (AW+1)'(push) - (AW+1)'(pop_q);
    assign slot_free = mem_state == IDLE || imem_ack;
    assign issue     = slot_free && !br_taken && count_nx < (AW+1)'(DEPTH);

    assign imem_req  = issue && rst;
    assign imem_addr = fetch_pc;
    assign out_valid = count != '0 || byp;
    assign out_pc4   = byp ? req_pc4 : pc4_q[rd_ptr];
    assign out_instr = byp ? imem_rdata : instr_q[rd_ptr];

    always_comb begin
        mem_state_nx = br_taken ? ((mem_state != IDLE && !imem_ack) ? DROP : IDLE) :
                       issue    ? WAIT :
                       imem_ack ? IDLE : mem_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_state <= IDLE;
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc4_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            mem_state <= mem_state_nx;
            if (br_taken) begin
                fetch_pc <= br_addr;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                count <= count_nx;
                if (issue) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (pop_q)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push) begin
                    pc4_q[wr_ptr]   <= req_pc4;
                    instr_q[wr_ptr] <= imem_rdata;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: table vectors, directed corner sequences and random traffic against a queue-based model.
// Memory answers 0x1000_0000+addr after a configurable latency.
module tb_if_fetch_queue;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0, rst = 1'b0, br_taken = 1'b0, freeze = 1'b0, imem_ack = 1'b0;
    logic [31:0] br_addr = '0, imem_rdata = '0;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, out_pc4, out_instr;

    if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
        .clk(clk), .rst(rst), .br_taken(br_taken), .br_addr(br_addr), .freeze(freeze),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_pc4(out_pc4), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc4; logic [31:0] instr; } ent_t;
    typedef struct { bit frz; bit req; logic [31:0] addr; bit valid; logic [31:0] pc4; } vec_t;

    ent_t        mq[$];
    bit          m_out, m_drop;
    logic [31:0] m_fetch, m_req;
    bit          pend;
    int          cnt, lat = 1;
    logic [31:0] paddr;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc4, s_instr;
    int          n_tests = 0, n_fail = 0;
    vec_t        tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit          ack, byp, pop, push, issue, ev;
        int          n, after;
        logic [31:0] epc4, einstr;
        if (pend) cnt--;
        imem_ack   = pend && cnt == 0;
        imem_rdata = imem_ack ? BASE + paddr : $urandom;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc4 = out_pc4; s_instr = out_instr;
        ack = imem_ack;
        n = mq.size();
        issue = 1'b0;
        if (!rst) begin
            chk("rst_req", s_req, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_pc4", s_pc4, 0);
            chk("rst_instr", s_instr, 0);
            mq.delete(); m_out = 0; m_drop = 0; m_fetch = 0; m_req = 0;
        end else begin
            byp    = BYP && n == 0 && m_out && !m_drop && ack && !br_taken;
            ev     = n > 0 || byp;
            epc4   = byp ? m_req + 4 : (n > 0 ? mq[0].pc4 : 32'h0);
            einstr = byp ? imem_rdata : (n > 0 ? mq[0].instr : 32'h0);
            pop    = n > 0 && !freeze && !br_taken;
            push   = m_out && !m_drop && ack && !br_taken && !(byp && !freeze);
            after  = n + int'(push) - int'(pop);
            issue  = (!m_out || ack) && !br_taken && after < DEPTH;
            chk("req", s_req, issue);
            if (issue) chk("addr", s_addr, m_fetch);
            chk("valid", s_valid, ev);
            if (ev) begin
                chk("pc4", s_pc4, epc4);
                chk("instr", s_instr, einstr);
            end
            if (br_taken) begin
                mq.delete();
                m_fetch = br_addr;
                issue = 1'b0;
                if (ack) begin m_out = 0; m_drop = 0; end
                else if (m_out) m_drop = 1;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back('{pc4: m_req + 4, instr: imem_rdata});
                if (ack) begin m_out = 0; m_drop = 0; end
            end
        end
        if (ack) pend = 0;
        if (issue) begin
            m_out = 1; m_drop = 0; m_req = m_fetch;
            pend = 1; cnt = lat; paddr = m_fetch;
            m_fetch = m_fetch + 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; br_taken = 1'b0; freeze = 1'b0;
        repeat (5) step();
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h4,  BYP,  32'h4};
        tbl[2]  = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[3]  = '{1'b1, 1'b1, 32'hc,  1'b1, 32'h4};
        for (int i = 4; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4};
        tbl[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
        tbl[11] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h8};
        tbl[12] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'hc};
        tbl[13] = '{1'b0, 1'b1, 32'h1c, 1'b1, 32'h10};
        tbl[14] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};

        do_reset();
        lat = 1;
        for (int i = 0; i < 15; i++) begin
            freeze = tbl[i].frz;
            step();
            chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_pc4", i), s_pc4, tbl[i].pc4);
                chk($sformatf("tbl%0d_instr", i), s_instr, BASE + tbl[i].pc4 - 32'h4);
            end
        end

        // redirect while a slow request is outstanding
        do_reset();
        lat = 3;
        step();
        chk("a_req0", s_req, 1);
        chk("a_addr0", s_addr, 0);
        br_taken = 1'b1; br_addr = 32'h200;
        step();
        br_taken = 1'b0;
        step();
        chk("a_valid", s_valid, 0);
        chk("a_drop_req", s_req, 0);
        step();
        chk("a_redir_req", s_req, 1);
        chk("a_redir_addr", s_addr, 32'h200);
        begin
            int k;
            for (k = 0; k < 10 && !s_valid; k++) step();
            chk("a_wait_valid", s_valid, 1);
            chk("a_first_pc4", s_pc4, 32'h204);
        end

        // redirect coinciding with an ack and a pop
        do_reset();
        lat = 1;
        repeat (3) step();
        chk("b_stream_addr", s_addr, 32'h8);
        chk("b_stream_pc4", s_pc4, BYP ? 32'h8 : 32'h4);
        br_taken = 1'b1; br_addr = 32'h300;
        step();
        br_taken = 1'b0;
        chk("b_br_req", s_req, 0);
        step();
        chk("b_valid", s_valid, 0);
        chk("b_req", s_req, 1);
        chk("b_addr", s_addr, 32'h300);

        // asynchronous reset mid-WAIT with three entries queued
        do_reset();
        lat = 3; freeze = 1'b1;
        begin
            int k;
            for (k = 0; k < 60 && !(mq.size() == 3 && m_out); k++) step();
            chk("c_setup", k < 60, 1);
        end
        chk("c_pre_valid", out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("c_async_valid", out_valid, 0);
        chk("c_async_req", imem_req, 0);
        repeat (4) step();
        rst = 1'b1; freeze = 1'b0; lat = 1;
        step();
        chk("c_restart_req", s_req, 1);
        chk("c_restart_addr", s_addr, 32'h0);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            freeze   = $urandom_range(0, 9) < 3;
            br_taken = $urandom_range(0, 19) == 0;
            br_addr  = $urandom & 32'hFFFF_FFFC;
            lat      = $urandom_range(1, 4);
            step();
        end

        // address wrap at the top of the space
        freeze = 1'b0; lat = 1;
        br_taken = 1'b1; br_addr = 32'hFFFF_FFFC;
        step();
        br_taken = 1'b0;
        begin
            int nreq;
            bit got;
            logic [31:0] a [2];
            nreq = 0; got = 0; a[0] = 'x; a[1] = 'x;
            for (int k = 0; k < 12 && !(got && nreq >= 2); k++) begin
                step();
                if (s_req && nreq < 2) begin a[nreq] = s_addr; nreq++; end
                if (s_valid && !got) begin got = 1; chk("d_wrap_pc4", s_pc4, 32'h0); end
            end
            chk("d_done", got && nreq == 2, 1);
            chk("d_addr0", a[0], 32'hFFFF_FFFC);
            chk("d_addr1", a[1], 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
